// File: rtl/rapcores_wb_spi_pkg.sv
// rapcores_wb_spi_pkg
// Shared constants for the Wishbone-to-SPI bridge: register offsets (word
// index adr[4:2]), STATUS bit positions, CLKDIV reset value and FSM states.
package rapcores_wb_spi_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_CLKDIV = 3'd1;
    localparam logic [2:0] REG_TXDATA = 3'd2;
    localparam logic [2:0] REG_RXDATA = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    localparam int ST_BUSY     = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_TX_EMPTY = 2;
    localparam int ST_RX_EMPTY = 3;
    localparam int ST_RX_FULL  = 4;
    localparam int ST_TX_OVF   = 5;
    localparam int ST_RX_OVF   = 6;
    localparam int ST_RX_UNF   = 7;

    localparam int CLKDIV_RST = 3;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

endpackage

// File: rtl/rapcores_wb_spi_if.sv
// rapcores_wb_spi_if
// Wishbone classic slave bundle.
//   wbs_cyc_i/stb_i/we_i : cycle, strobe, write enable (master -> slave)
//   wbs_sel_i            : byte enables
//   wbs_adr_i/dat_i      : byte address, write data
//   wbs_ack_o/dat_o      : acknowledge, read data (slave -> master)
interface rapcores_wb_spi_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/rapcores_sync_fifo.sv
// rapcores_sync_fifo
// Single-clock FIFO, first-word-fall-through read port.
//   clk, rst        : clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_data  : write; ignored while full
//   i_pop           : read; ignored while empty
//   o_data          : word at the head
//   o_full, o_empty, o_count : occupancy
module rapcores_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // Extra MSB on each pointer tells full from empty when the indices match.
    logic [AW:0]      r_wptr, r_rptr;
    logic             w_do_push, w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_count   = r_wptr - r_rptr;
    assign o_data    = r_mem[r_rptr[AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/rapcores_wb_spi.sv
// rapcores_wb_spi
// Wishbone slave that serialises 32-bit TX words as an SPI mode-0 master
// (MSB first) and collects the returned words in an RX FIFO.
//   wb_clk_i, wb_rst_i : sole clock, synchronous active-high reset
//   wb                 : Wishbone classic slave (rapcores_wb_spi_if.slave)
//   spi_sck/cs/copi    : SPI outputs (cs active low)
//   spi_cipo           : SPI input, already synchronous to wb_clk_i
module rapcores_wb_spi
    import rapcores_wb_spi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          DIV_W      = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    rapcores_wb_spi_if.slave wb,
    output logic             spi_sck,
    output logic             spi_cs,
    output logic             spi_copi,
    input  logic             spi_cipo
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic             r_ack;
    logic [31:0]      r_dat;
    logic             r_hold;
    logic [DIV_W-1:0] r_clkdiv, r_div_lat, r_cnt;
    logic             r_tx_ovf, r_rx_ovf, r_rx_unf;
    state_t           r_state, w_next;
    logic [31:0]      r_shift;
    logic             r_sample, r_sck, r_done;
    logic [4:0]       r_bit;

    logic        w_acc, w_wr, w_rd, w_clr;
    logic [2:0]  w_off;
    logic        w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
    logic        w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
    logic [31:0] w_tx_data, w_rx_data, w_shift_nxt, w_status;
    logic [CW-1:0] w_tx_count, w_rx_count;
    logic        w_unused;

    // One access per ack; the ~r_ack term keeps ack from repeating back to back.
    assign w_acc     = wb.wbs_cyc_i && wb.wbs_stb_i && !r_ack
                       && (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign w_wr      = w_acc && wb.wbs_we_i;
    assign w_rd      = w_acc && !wb.wbs_we_i;
    assign w_off     = wb.wbs_adr_i[4:2];
    assign w_clr     = w_wr && (w_off == REG_STATUS);
    assign w_tx_push = w_wr && (w_off == REG_TXDATA);
    assign w_rx_pop  = w_rd && (w_off == REG_RXDATA);

    // Word completes on the falling edge that ends bit 31's high half.
    assign w_shift_nxt = {r_shift[30:0], r_sample};
    assign w_rx_push   = (r_state == SHIFT) && !r_done && r_sck
                         && (r_cnt == '0) && (r_bit == 5'd31);

    assign wb.wbs_ack_o = r_ack;
    assign wb.wbs_dat_o = r_dat;
    assign spi_sck      = r_sck;
    assign spi_cs       = (r_state == IDLE) || (r_state == GAP);
    assign spi_copi     = !spi_cs && r_shift[31];

    assign w_unused = ^{wb.wbs_adr_i[7:5], wb.wbs_adr_i[1:0], wb.wbs_sel_i,
                        w_tx_count, w_rx_count};

    rapcores_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(wb_clk_i), .rst(wb_rst_i),
        .i_push(w_tx_push), .i_data(wb.wbs_dat_i), .i_pop(w_tx_pop),
        .o_data(w_tx_data), .o_full(w_tx_full), .o_empty(w_tx_empty), .o_count(w_tx_count)
    );

    rapcores_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(wb_clk_i), .rst(wb_rst_i),
        .i_push(w_rx_push), .i_data(w_shift_nxt), .i_pop(w_rx_pop),
        .o_data(w_rx_data), .o_full(w_rx_full), .o_empty(w_rx_empty), .o_count(w_rx_count)
    );

    always_comb begin
        w_status              = '0;
        w_status[ST_BUSY]     = (r_state != IDLE);
        w_status[ST_TX_FULL]  = w_tx_full;
        w_status[ST_TX_EMPTY] = w_tx_empty;
        w_status[ST_RX_EMPTY] = w_rx_empty;
        w_status[ST_RX_FULL]  = w_rx_full;
        w_status[ST_TX_OVF]   = r_tx_ovf;
        w_status[ST_RX_OVF]   = r_rx_ovf;
        w_status[ST_RX_UNF]   = r_rx_unf;
    end

    // Register file and Wishbone response.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_hold   <= 1'b0;
            r_clkdiv <= DIV_W'(CLKDIV_RST);
            r_tx_ovf <= 1'b0;
            r_rx_ovf <= 1'b0;
            r_rx_unf <= 1'b0;
        end else begin
            r_ack <= w_acc;
            r_dat <= '0;
            if (w_rd) begin
                case (w_off)
                    REG_CTRL:   r_dat <= {31'b0, r_hold};
                    REG_CLKDIV: r_dat <= 32'(r_clkdiv);
                    REG_RXDATA: r_dat <= w_rx_empty ? 32'h0 : w_rx_data;
                    REG_STATUS: r_dat <= w_status;
                    default:    r_dat <= '0;
                endcase
            end
            if (w_wr && (w_off == REG_CTRL) && wb.wbs_sel_i[0])
                r_hold <= wb.wbs_dat_i[0];
            if (w_wr && (w_off == REG_CLKDIV)) begin
                for (int i = 0; i < DIV_W; i++)
                    if (wb.wbs_sel_i[i/8]) r_clkdiv[i] <= wb.wbs_dat_i[i];
            end
            // Sticky, write-1-to-clear; a same-cycle set beats the clear.
            r_tx_ovf <= (w_tx_push && w_tx_full)  || (r_tx_ovf && !(w_clr && wb.wbs_dat_i[ST_TX_OVF]));
            r_rx_ovf <= (w_rx_push && w_rx_full)  || (r_rx_ovf && !(w_clr && wb.wbs_dat_i[ST_RX_OVF]));
            r_rx_unf <= (w_rx_pop  && w_rx_empty) || (r_rx_unf && !(w_clr && wb.wbs_dat_i[ST_RX_UNF]));
        end
    end

    // r_done marks the one SCK-low cycle after a word completes, where the
    // back-to-back / HOLD / GAP decision is taken.
    always_comb begin
        w_next   = r_state;
        w_tx_pop = 1'b0;
        case (r_state)
            IDLE:  if (!w_tx_empty) begin w_tx_pop = 1'b1; w_next = SETUP; end
            SETUP: if (r_cnt == '0) w_next = SHIFT;
            SHIFT: if (r_done) begin
                       if (!w_tx_empty) w_tx_pop = 1'b1;
                       else if (r_hold) w_next = HOLD;
                       else             w_next = GAP;
                   end
            HOLD:  if (!w_tx_empty) begin w_tx_pop = 1'b1; w_next = SHIFT; end
                   else if (!r_hold) w_next = GAP;
            GAP:   if (r_cnt == '0) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_div_lat <= '0;
            r_shift   <= '0;
            r_sample  <= 1'b0;
            r_sck     <= 1'b0;
            r_done    <= 1'b0;
            r_bit     <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            if (w_tx_pop) begin
                // Divider is latched only here, so CLKDIV never changes mid-word.
                r_shift   <= w_tx_data;
                r_div_lat <= r_clkdiv;
                r_cnt     <= r_clkdiv;
                r_bit     <= '0;
                r_sck     <= 1'b0;
            end else begin
                case (r_state)
                    SETUP: r_cnt <= (r_cnt == '0) ? r_div_lat : r_cnt - 1'b1;
                    SHIFT: if (!r_done) begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else begin
                            r_cnt <= r_div_lat;
                            if (!r_sck) begin
                                r_sck    <= 1'b1;
                                r_sample <= spi_cipo;
                            end else begin
                                r_sck   <= 1'b0;
                                r_shift <= w_shift_nxt;
                                r_bit   <= r_bit + 5'd1;
                                if (r_bit == 5'd31) r_done <= 1'b1;
                            end
                        end
                    end
                    GAP:   if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                    default: ;
                endcase
                if ((w_next == GAP) && (r_state != GAP)) r_cnt <= r_div_lat;
            end
        end
    end
endmodule
